// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external 8-bit combinational ALU between two requesters. A port
// is granted round-robin, its operands are registered and presented to the
// ALU for one cycle, and the ALU result is captured and returned on that
// port's response handshake. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid_n / req_ready_n     request handshake for port n (n = 0, 1)
//   req_op_n, req_a_n, req_b_n    ALU control code and operands for port n
//   rsp_valid_n / rsp_ready_n     response handshake for port n
//   rsp_y, rsp_ovf, rsp_zero      captured result, shared by both ports
//   alu_a, alu_b, alu_ctrl        registered operands/op driven to the ALU
//   alu_y, alu_ovf, alu_zero      ALU result inputs
// -----------------------------------------------------------------------------
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid_0,
    input  logic       req_valid_1,
    output logic       req_ready_0,
    output logic       req_ready_1,
    input  logic [3:0] req_op_0,
    input  logic [3:0] req_op_1,
    input  logic [7:0] req_a_0,
    input  logic [7:0] req_b_0,
    input  logic [7:0] req_a_1,
    input  logic [7:0] req_b_1,
    output logic       rsp_valid_0,
    output logic       rsp_valid_1,
    input  logic       rsp_ready_0,
    input  logic       rsp_ready_1,
    output logic [7:0] rsp_y,
    output logic       rsp_ovf,
    output logic       rsp_zero,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_ctrl,
    input  logic [7:0] alu_y,
    input  logic       alu_ovf,
    input  logic       alu_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       owner_q, owner_d;
    logic [3:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] rsp_y_q, rsp_y_d;
    logic       rsp_ovf_q, rsp_ovf_d;
    logic       rsp_zero_q, rsp_zero_d;

    logic       grant;
    logic       accept;
    logic       rsp_done;

    // On a tie the port that did not win last time gets the grant, which
    // makes continuous contention alternate strictly between the ports.
    always_comb begin
        grant = 1'b0;
        case ({req_valid_1, req_valid_0})
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    assign req_ready_0 = (state_q == IDLE) && req_valid_0 && (grant == 1'b0);
    assign req_ready_1 = (state_q == IDLE) && req_valid_1 && (grant == 1'b1);
    assign accept      = req_ready_0 | req_ready_1;

    // Only the owner's rsp_ready can retire the response.
    assign rsp_done = (state_q == RESP) && (owner_q ? rsp_ready_1 : rsp_ready_0);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_y_d      = rsp_y_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_zero_d   = rsp_zero_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d         = grant ? req_op_1 : req_op_0;
                    a_d          = grant ? req_a_1  : req_a_0;
                    b_d          = grant ? req_b_1  : req_b_0;
                    owner_d      = grant;
                    last_grant_d = grant;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d    = alu_y;
                rsp_ovf_d  = alu_ovf;
                rsp_zero_d = alu_zero;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= 4'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            rsp_y_q      <= 8'd0;
            rsp_ovf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_y_q      <= rsp_y_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign rsp_valid_0 = (state_q == RESP) && (owner_q == 1'b0);
    assign rsp_valid_1 = (state_q == RESP) && (owner_q == 1'b1);
    assign rsp_y       = rsp_y_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_zero    = rsp_zero_q;

    assign alu_ctrl = op_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives directed requests into alu_arbiter and models the external ALU.
// Every accepted request pushes its hand-computed response into a scoreboard
// queue; an independent monitor pops and compares on each response handshake.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req_valid_0, req_valid_1;
    logic       req_ready_0, req_ready_1;
    logic [3:0] req_op_0, req_op_1;
    logic [7:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic       rsp_valid_0, rsp_valid_1;
    logic       rsp_ready_0, rsp_ready_1;
    logic [7:0] rsp_y;
    logic       rsp_ovf, rsp_zero;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_y;
    logic       alu_ovf, alu_zero;

    typedef struct {
        logic       port;
        logic [7:0] y;
        logic       ovf;
        logic       zero;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_0 (req_valid_0),
        .req_valid_1 (req_valid_1),
        .req_ready_0 (req_ready_0),
        .req_ready_1 (req_ready_1),
        .req_op_0    (req_op_0),
        .req_op_1    (req_op_1),
        .req_a_0     (req_a_0),
        .req_b_0     (req_b_0),
        .req_a_1     (req_a_1),
        .req_b_1     (req_b_1),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_ready_0 (rsp_ready_0),
        .rsp_ready_1 (rsp_ready_1),
        .rsp_y       (rsp_y),
        .rsp_ovf     (rsp_ovf),
        .rsp_zero    (rsp_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_y       (alu_y),
        .alu_ovf     (alu_ovf),
        .alu_zero    (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the shared ALU; ovf is the carry/borrow out of add/sub.
    always_comb begin
        logic [8:0] wide;
        wide    = 9'd0;
        alu_y   = 8'd0;
        alu_ovf = 1'b0;
        case (alu_ctrl)
            4'd0: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = wide[7:0]; alu_ovf = wide[8]; end
            4'd1: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_y = wide[7:0]; alu_ovf = wide[8]; end
            4'd2: alu_y = alu_a & alu_b;
            4'd3: alu_y = alu_a | alu_b;
            4'd4: alu_y = alu_b;
            4'd5: alu_y = {7'd0, &alu_b};
            4'd6: alu_y = {7'd0, |alu_b};
            4'd7: alu_y = alu_a << alu_b[2:0];
            4'd8: alu_y = alu_a ^ alu_b;
            default: alu_y = 8'd0;
        endcase
        alu_zero = (alu_y == 8'd0);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input logic port, input logic [7:0] y, input logic ovf, input logic zero);
        exp_t e;
        e.port = port;
        e.y    = y;
        e.ovf  = ovf;
        e.zero = zero;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: compares on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid_0 && rsp_valid_1) begin
                checkOutput("rsp_valid_onehot", {31'd0, rsp_valid_0 & rsp_valid_1}, 32'd0);
            end else if (rsp_valid_0 || rsp_valid_1) begin
                if (sb.size() == 0) begin
                    checkOutput("rsp_without_request", {31'd0, rsp_valid_0 | rsp_valid_1}, 32'd0);
                end else if ((rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1)) begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("rsp_port", {31'd0, rsp_valid_1}, {31'd0, e.port});
                    checkOutput("rsp_y",    {24'd0, rsp_y},       {24'd0, e.y});
                    checkOutput("rsp_ovf",  {31'd0, rsp_ovf},     {31'd0, e.ovf});
                    checkOutput("rsp_zero", {31'd0, rsp_zero},    {31'd0, e.zero});
                end
            end
        end
    end

    task automatic resetDut();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rsp_valid_0"}, {31'd0, rsp_valid_0}, 32'd0);
        checkOutput({tag, "_rsp_valid_1"}, {31'd0, rsp_valid_1}, 32'd0);
        checkOutput({tag, "_rsp_y"},       {24'd0, rsp_y},       32'd0);
        checkOutput({tag, "_rsp_ovf"},     {31'd0, rsp_ovf},     32'd0);
        checkOutput({tag, "_rsp_zero"},    {31'd0, rsp_zero},    32'd0);
        checkOutput({tag, "_alu_a"},       {24'd0, alu_a},       32'd0);
        checkOutput({tag, "_alu_b"},       {24'd0, alu_b},       32'd0);
        checkOutput({tag, "_alu_ctrl"},    {28'd0, alu_ctrl},    32'd0);
    endtask

    // Drives one request and waits (bounded) for acceptance; call after a negedge.
    task automatic applyStimulus(input logic port, input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] ey, input logic eovf,
                                 input logic ezero);
        int accepted;
        accepted = 0;
        if (port) begin
            req_op_1 = op; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1;
        end else begin
            req_op_0 = op; req_a_0 = a; req_b_0 = b; req_valid_0 = 1'b1;
        end
        for (int i = 0; i < 50 && accepted == 0; i++) begin
            #1;
            if (port ? req_ready_1 : req_ready_0) begin
                pushExp(port, ey, eovf, ezero);
                @(posedge clk);
                #1;
                if (port) req_valid_1 = 1'b0;
                else      req_valid_0 = 1'b0;
                accepted = 1;
            end else begin
                @(negedge clk);
            end
        end
        checkOutput("accept_timeout", accepted, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        int   acc0;
        int   acc1;
        int   accCyc[4];
        logic accPort[4];

        rst_n = 1'b0;
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_op_0 = 4'd0; req_a_0 = 8'd0; req_b_0 = 8'd0;
        req_op_1 = 4'd0; req_a_1 = 8'd0; req_b_1 = 8'd0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;

        // Reset values, then a single port-0 add with carry out.
        resetDut();
        #1;
        checkResetOutputs("reset");
        checkOutput("idle_ready_0", {31'd0, req_ready_0}, 32'd0);
        req_op_0 = 4'd0; req_a_0 = 8'd200; req_b_0 = 8'd100; req_valid_0 = 1'b1;
        #1;
        checkOutput("t1_ready_0", {31'd0, req_ready_0}, 32'd1);
        checkOutput("t1_ready_1", {31'd0, req_ready_1}, 32'd0);
        applyStimulus(1'b0, 4'd0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t1_exec_no_rsp", {31'd0, rsp_valid_0}, 32'd0);
        checkOutput("t1_alu_a",       {24'd0, alu_a},       32'd200);
        checkOutput("t1_alu_b",       {24'd0, alu_b},       32'd100);
        @(negedge clk);
        checkOutput("t1_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
        checkOutput("t1_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
        @(negedge clk);
        checkOutput("t1_back_idle",   {31'd0, rsp_valid_0}, 32'd0);

        // Both ports continuously valid: grants must alternate, 3 cycles apart.
        resetDut();
        req_op_0 = 4'd1; req_a_0 = 8'd5;    req_b_0 = 8'd5;
        req_op_1 = 4'd8; req_a_1 = 8'h0F;   req_b_1 = 8'hF0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        n = 0; acc0 = 0; acc1 = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            #1;
            if (req_ready_0 && req_ready_1) begin
                checkOutput("req_ready_onehot", {31'd0, req_ready_0 & req_ready_1}, 32'd0);
            end
            if (req_ready_0 || req_ready_1) begin
                if (req_ready_0) pushExp(1'b0, 8'h00, 1'b0, 1'b1);
                else             pushExp(1'b1, 8'hFF, 1'b0, 1'b0);
                accPort[n] = req_ready_1;
                accCyc[n]  = cyc;
                if (req_ready_0) acc0++;
                else             acc1++;
                n++;
                @(posedge clk);
                #1;
                if (acc0 == 2) req_valid_0 = 1'b0;
                if (acc1 == 2) req_valid_1 = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("rr_accept_count", n, 32'd4);
        for (int k = 0; k < n; k++) begin
            checkOutput("rr_grant_order", {31'd0, accPort[k]}, k % 2);
            if (k > 0) checkOutput("rr_accept_spacing", accCyc[k] - accCyc[k-1], 32'd3);
        end
        repeat (5) @(negedge clk);

        // Response backpressure on port 1 while port 0 waits.
        rsp_ready_1 = 1'b0;
        applyStimulus(1'b1, 4'd7, 8'h03, 8'd2, 8'h0C, 1'b0, 1'b0);
        req_op_0 = 4'd3; req_a_0 = 8'h50; req_b_0 = 8'h05; req_valid_0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
            checkOutput("bp_rsp_y",       {24'd0, rsp_y},       32'h0C);
            checkOutput("bp_ready_0",     {31'd0, req_ready_0}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready_1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_ready0_after", {31'd0, req_ready_0}, 32'd1);
        applyStimulus(1'b0, 4'd3, 8'h50, 8'h05, 8'h55, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        // Illegal op code is forwarded; the ALU yields zero.
        applyStimulus(1'b1, 4'hB, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("illegal_ctrl_fwd", {28'd0, alu_ctrl}, 32'hB);
        repeat (4) @(negedge clk);

        // Reset during EXEC.
        applyStimulus(1'b0, 4'd0, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkResetOutputs("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during RESP with the response stalled.
        rsp_ready_1 = 1'b0;
        applyStimulus(1'b1, 4'd0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd1);
        checkOutput("pre_rst_rsp_y",       {24'd0, rsp_y},       32'd7);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checkResetOutputs("rst_resp");
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready_1 = 1'b1;
        repeat (3) @(negedge clk);

        // First tie after reset goes to port 0, then port 1 is served.
        req_op_0 = 4'd0; req_a_0 = 8'd10;  req_b_0 = 8'd20;
        req_op_1 = 4'd2; req_a_1 = 8'hF0;  req_b_1 = 8'h3C;
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        #1;
        checkOutput("post_rst_tie_0", {31'd0, req_ready_0}, 32'd1);
        checkOutput("post_rst_tie_1", {31'd0, req_ready_1}, 32'd0);
        applyStimulus(1'b0, 4'd0, 8'd10, 8'd20, 8'd30, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        repeat (6) @(negedge clk);

        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
